temp_level_classifier: RTL
==========================

Name: temp_level_classifier

Overview:
- Front-end stage that feeds the alarm/notification state machine.
- Converts a sampled integer temperature and a raw body-presence sensor line into the registered one-hot condition flags t_25, t_27, t_30 and t_corp that the state machine consumes.
- Applies a persistence filter, falling hysteresis, presence debouncing and a stale-sample timeout, so the downstream FSM never sees sensor noise.

Parameters:
- TEMP_W, 8, width of unsigned temperature sample in whole °C
- PERSIST, 4, consecutive valid samples required to commit a new level (>=1)
- HYST, 1, °C margin required to fall out of a level
- DEB_CYCLES, 16, stable clocks required to flip debounced presence
- TIMEOUT_CYCLES, 1000, clocks without temp_valid before declaring stale

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- temp  in  TEMP_W  unsigned temperature sample, °C
- temp_valid  in  1  single-cycle strobe qualifying temp
- corp_raw  in  1  asynchronous body-presence sensor level
- t_25  out  1  committed level is 25..26 °C and no presence
- t_27  out  1  committed level is 27..29 °C and no presence
- t_30  out  1  committed level is >=30 °C and no presence
- t_corp  out  1  debounced presence asserted
- level  out  2  committed level: 0 none, 1 L25, 2 L27, 3 L30
- stale  out  1  no temp_valid for TIMEOUT_CYCLES clocks

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; level=0; pending=0; persistence count=0; debounce state and counter=0; timeout counter=0; synchronizer flops=0.
- Plain classify(x): x>=30 gives 3, x>=27 gives 2, x>=25 gives 1, otherwise 0.
- Candidate on temp_valid:
  - c=classify(temp). If c>=level, candidate=c.
  - Otherwise candidate=classify(min(temp+HYST, 2^TEMP_W-1)). Falling therefore requires temp+HYST < threshold.
- Persistence, on each temp_valid:
  - If candidate==level: count=0.
  - Else if candidate==pending and count>0: count+1. When this reaches PERSIST, commit level=candidate and clear count.
  - Else: pending=candidate, count=1. With PERSIST=1 this commits immediately.
  - Cycles without temp_valid leave pending and count untouched.
- Latency: level and flags update on the clock edge that samples the PERSIST-th qualifying temp_valid. New values are visible the following cycle.
- Presence path:
  - corp_raw passes through a 2-flop synchronizer.
  - Debounce counter increments while the synchronized value != debounced state and clears when they are equal.
  - At DEB_CYCLES the debounced state flips and the counter clears.
  - Latency from a clean edge = 2 + DEB_CYCLES clocks.
- Flag encoding (registered):
  - t_corp = deb.
  - t_30 = (level==3) & ~deb; t_27 = (level==2) & ~deb; t_25 = (level==1) & ~deb.
  - At most one flag is high at any time; all four low means nominal.
- Stale handling:
  - Timeout counter clears on every temp_valid and otherwise increments, saturating.
  - On reaching TIMEOUT_CYCLES: stale=1, level=0, pending=0, count=0.
  - t_corp is unaffected by stale.
  - The next temp_valid clears stale on the same edge and is processed normally from level 0.
- Simultaneous events: a presence flip and a level commit on the same edge both update. Flags reflect the priority above. Timeout and temp_valid on the same edge: temp_valid wins, no stale.
- Widths: count is clog2(PERSIST+1) bits, debounce counter clog2(DEB_CYCLES+1), timeout counter clog2(TIMEOUT_CYCLES+1). Hysteresis addition saturates, no wrap.

Decomposition:
- Package temp_levels_pkg:
  - Constants T25=25, T27=27, T30=30.
  - Level typedef (LVL_NONE, LVL_25, LVL_27, LVL_30).
  - classify function.
- One sub-module: sync_debounce (2-flop synchronizer plus DEB_CYCLES debounce), instantiated for corp_raw.

Test Plan:
1. Reset release, then 10 valids of temp=20 -> all flags 0, level=0, stale=0.
2. temp=26 x3 then 20 x1 -> no change. Then 26 x4 -> t_25=1, level=1 the cycle after the 4th valid.
3. Commit level 2 with temp=28 x4. Then 26 x4 -> t_27 held (26+1 not <27). Then 25 x4 -> t_25=1.
4. corp_raw high for 10 clocks -> t_corp stays 0. High for 20 clocks with level=3 -> t_corp=1 and t_30=0 at 18 clocks after the edge. corp_raw low for 18 clocks -> t_30=1 again.
5. No temp_valid for 1000 clocks -> stale=1, level=0, flags 0. Then temp=31 x4 -> stale=0 after the 1st valid, t_30=1 after the 4th.
6. Assert reset between the 2nd and 3rd of four temp=28 valids -> outputs 0 immediately. After release, 28 x4 is needed to reach t_27.

Source files
------------

// File: rtl/temp_levels_pkg.sv
// Shared temperature thresholds, level encoding and the plain classifier
// used by the temperature level front-end.
package temp_levels_pkg;

    localparam int T25 = 25;
    localparam int T27 = 27;
    localparam int T30 = 30;

    typedef enum logic [1:0] {
        LVL_NONE = 2'd0,
        LVL_25   = 2'd1,
        LVL_27   = 2'd2,
        LVL_30   = 2'd3
    } level_t;

    function automatic level_t classify(input logic [31:0] x);
        if (x >= 32'(T30))      return LVL_30;
        else if (x >= 32'(T27)) return LVL_27;
        else if (x >= 32'(T25)) return LVL_25;
        else                    return LVL_NONE;
    endfunction

endpackage

// File: rtl/temp_level_classifier_sync_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer; deb_nxt lets
// the parent register derived flags on the same edge that deb flips.
module sync_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic deb,
    output logic deb_nxt
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        deb_nxt = deb;
        cnt_nxt = '0;
        if (sync_q[1] != deb) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) deb_nxt = ~deb;
            else                              cnt_nxt = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            cnt_q  <= cnt_nxt;
            deb    <= deb_nxt;
        end
    end

endmodule

// File: rtl/temp_level_classifier.sv
// Turns sampled temperature and raw presence into filtered, registered
// one-hot condition flags for the alarm state machine.
module temp_level_classifier
    import temp_levels_pkg::*;
#(
    parameter int TEMP_W         = 8,
    parameter int PERSIST        = 4,
    parameter int HYST           = 1,
    parameter int DEB_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TEMP_W-1:0] temp,
    input  logic              temp_valid,
    input  logic              corp_raw,
    output logic              t_25,
    output logic              t_27,
    output logic              t_30,
    output logic              t_corp,
    output logic [1:0]        level,
    output logic              stale
);

    localparam int          PCW  = $clog2(PERSIST + 1);
    localparam int          TCW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] TMAX = 32'((64'd1 << TEMP_W) - 64'd1);

    level_t         level_q, level_nxt, pend_q, pend_nxt, cand, c_raw;
    logic [PCW-1:0] pcnt_q, pcnt_nxt;
    logic [TCW-1:0] tcnt_q, tcnt_nxt;
    logic           stale_q, stale_nxt;
    logic           deb, deb_nxt;
    logic [31:0]    t_ext, t_hyst;

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_corp (
        .clk     (clk),
        .reset   (reset),
        .din     (corp_raw),
        .deb     (deb),
        .deb_nxt (deb_nxt)
    );

    // Falling out of a level needs temp+HYST below the threshold; the sum saturates.
    always_comb begin
        t_ext  = 32'(temp);
        t_hyst = t_ext + 32'(HYST);
        if (t_hyst > TMAX) t_hyst = TMAX;
        c_raw = classify(t_ext);
        cand  = (c_raw >= level_q) ? c_raw : classify(t_hyst);
    end

    always_comb begin
        level_nxt = level_q;
        pend_nxt  = pend_q;
        pcnt_nxt  = pcnt_q;
        tcnt_nxt  = tcnt_q;
        stale_nxt = stale_q;
        if (temp_valid) begin
            tcnt_nxt  = '0;
            stale_nxt = 1'b0;
            if (cand == level_q) begin
                pcnt_nxt = '0;
            end else if (cand == pend_q && pcnt_q != '0) begin
                if (pcnt_q == PCW'(PERSIST - 1)) begin
                    level_nxt = cand;
                    pcnt_nxt  = '0;
                end else begin
                    pcnt_nxt = pcnt_q + 1'b1;
                end
            end else begin
                pend_nxt = cand;
                if (PERSIST == 1) begin
                    level_nxt = cand;
                    pcnt_nxt  = '0;
                end else begin
                    pcnt_nxt = PCW'(1);
                end
            end
        end else if (tcnt_q != TCW'(TIMEOUT_CYCLES)) begin
            tcnt_nxt = tcnt_q + 1'b1;
            if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                stale_nxt = 1'b1;
                level_nxt = LVL_NONE;
                pend_nxt  = LVL_NONE;
                pcnt_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= LVL_NONE;
            pend_q  <= LVL_NONE;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
            stale_q <= 1'b0;
            t_25    <= 1'b0;
            t_27    <= 1'b0;
            t_30    <= 1'b0;
            t_corp  <= 1'b0;
        end else begin
            level_q <= level_nxt;
            pend_q  <= pend_nxt;
            pcnt_q  <= pcnt_nxt;
            tcnt_q  <= tcnt_nxt;
            stale_q <= stale_nxt;
            // Presence masks every temperature flag so at most one flag is ever high.
            t_25    <= (level_nxt == LVL_25) & ~deb_nxt;
            t_27    <= (level_nxt == LVL_27) & ~deb_nxt;
            t_30    <= (level_nxt == LVL_30) & ~deb_nxt;
            t_corp  <= deb_nxt;
        end
    end

    assign level = level_q;
    assign stale = stale_q;

endmodule
